rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset generator for flops with asynchronous active-low reset/set pins.
- Asserts all domain resets asynchronously and immediately when resetb goes low.
- Deasserts them synchronously to clk, one stage at a time, in a fixed order with a programmable gap between stages.
- Supports a software-requested warm reset that re-runs the same release sequence.
- Sits at the top of each clock domain, feeding resetb of the downstream flop banks.

Parameters:
SYNC_STAGES, 2, depth of the resetb deassertion synchronizer (≥2)
NUM_OUT, 3, number of sequenced reset outputs (≥1)
STAGE_DLY, 16, clk cycles between successive output releases (≥1)
HOLD_CYC, 8, clk cycles all outputs are held low on a software reset (≥1)
CNT_W, 8, counter width; must hold max(STAGE_DLY, HOLD_CYC)

Ports:
clk  input  1  clock
resetb  input  1  reset, asynchronous, active-low
sw_rst  input  1  synchronous warm-reset request, sampled on the clk rising edge
rst_outb  output  NUM_OUT  sequenced active-low resets; bit 0 is released first
rst_done  output  1  high when all rst_outb are released
busy  output  1  equals the inverse of rst_done

Behaviour:
- Asynchronous reset (resetb low):
  - rst_outb=all 0, rst_done=0, busy=1, with no clock required.
  - Synchronizer flops, counter and FSM are asynchronously cleared to state RST.
  - A resetb low pulse shorter than one clk period must still produce the full reset.
- Synchronizer:
  - SYNC_STAGES flops, each async-cleared by resetb, D of the first tied high.
  - sync_ok = last stage output.
  - No output is released until sync_ok is high.
- FSM states: RST, RELEASE, DONE, HOLD.
  - RST -> RELEASE on the first edge where sync_ok=1. The counter clears on this transition.
  - RELEASE:
    - Counter increments each edge.
    - On reaching STAGE_DLY, set rst_outb[idx]=1, increment idx and clear the counter.
    - After bit NUM_OUT-1 is released, go to DONE on that same edge.
  - DONE: rst_done=1. Outputs are held released.
  - HOLD:
    - All rst_outb=0, rst_done=0.
    - Counter counts HOLD_CYC edges, then moves to RELEASE with the counter and idx cleared.
- Release timing:
  - Edges are numbered from the first clk rising edge with resetb high (E1).
  - rst_outb[k] rises at edge E(SYNC_STAGES + (k+1)*STAGE_DLY).
  - rst_done rises on the same edge as rst_outb[NUM_OUT-1].
- Monotonicity: once released, rst_outb[k] stays 1 until a reset event. Lower-index bits are always released no later than higher-index bits.
- sw_rst in DONE, sampled 1 at edge Es:
  - At Es: all rst_outb=0, rst_done=0, state HOLD.
  - rst_outb[0] rises at Es + HOLD_CYC + STAGE_DLY.
- sw_rst in RELEASE: restart. Drive all outputs low and go to HOLD, same timing as from DONE.
- sw_rst in HOLD or RST: ignored. The hold period is not extended.
- resetb low at any time, including mid-RELEASE or mid-HOLD, overrides everything and forces state RST asynchronously.
- Outputs are driven directly from flops (glitch-free); no combinational path from sw_rst to rst_outb.

Test Plan:
1. Power-on sequence (defaults, STAGE_DLY=4): resetb 0→1 before E1 -> rst_outb 000→001 at E6, 011 at E10, 111 at E14; rst_done=1 at E14; busy=0.
2. Async assert: in DONE, pull resetb low mid-cycle for 0.3 clk period -> rst_outb=000 and rst_done=0 immediately, with no clk edge required; after release, the full sequence replays with the case 1 timing.
3. Warm reset: in DONE, sw_rst=1 at edge Es, with STAGE_DLY=4 and HOLD_CYC=8 -> outputs 000 at Es; 001 at Es+12; 011 at Es+16; 111 and rst_done=1 at Es+20.
4. sw_rst mid-release: sw_rst pulse after rst_outb=001 -> 000 on that edge; sequence restarts from HOLD. An sw_rst during HOLD does not extend it; 001 appears exactly HOLD_CYC+STAGE_DLY after the first request.
5. resetb low mid-HOLD and mid-RELEASE -> immediate 000 and state RST; the next release timing is measured from the new resetb rise.
6. Corner parameters (NUM_OUT=1, STAGE_DLY=1, SYNC_STAGES=3) -> rst_outb[0] and rst_done rise at E4; monotonicity checker passes across randomized resetb/sw_rst stimulus.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for one clock domain.
// All rst_outb bits drop asynchronously as soon as resetb goes low.
// They are released synchronously to clk, bit 0 first, with STAGE_DLY cycles
// between releases. sw_rst holds everything low for HOLD_CYC cycles and then
// runs the same release sequence again.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int STAGE_DLY   = 16,
  parameter int HOLD_CYC    = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               sw_rst,
  output logic [NUM_OUT-1:0] rst_outb,
  output logic               rst_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_RELEASE,
    ST_DONE,
    ST_HOLD
  } state_e;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_OUT-1:0]     rst_outb_q;
  logic                   rst_done_q;
  logic                   busy_q;
  logic [NUM_OUT-1:0]     rel_next;
  logic                   stage_hit;
  logic                   hold_hit;

  // Deassertion synchronizer: a 1 ripples in once resetb is high, and every
  // stage is cleared asynchronously when resetb goes low.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  // The release pattern is a thermometer code, so the next pattern is the
  // current one shifted up by one set bit. Its top bit says this release is
  // the last one.
  if (NUM_OUT == 1) begin : g_single
    assign rel_next = 1'b1;
  end else begin : g_multi
    assign rel_next = {rst_outb_q[NUM_OUT-2:0], 1'b1};
  end

  assign stage_hit = (cnt_q == STAGE_LAST);
  assign hold_hit  = (cnt_q == HOLD_LAST);

  // Sequencing FSM. The counter and all outputs are registered here, so no
  // combinational path runs from sw_rst to rst_outb.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_RST;
      cnt_q      <= '0;
      rst_outb_q <= '0;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        // The edge that first sees sync_ok counts as the first edge of the
        // bit-0 stage. This puts bit k at edge SYNC_STAGES + (k+1)*STAGE_DLY.
        // cnt_q is always zero in ST_RST, so one step covers both states.
        ST_RST, ST_RELEASE: begin
          if (state_q == ST_RELEASE && sw_rst) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            rst_outb_q <= '0;
          end else if (state_q == ST_RELEASE || sync_ok) begin
            if (stage_hit) begin
              rst_outb_q <= rel_next;
              cnt_q      <= '0;
              if (rel_next[NUM_OUT-1]) begin
                state_q    <= ST_DONE;
                rst_done_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_DONE: begin
          if (sw_rst) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            rst_outb_q <= '0;
            rst_done_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        // sw_rst is ignored here, so a second request does not extend the hold.
        ST_HOLD: begin
          if (hold_hit) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign rst_outb = rst_outb_q;
  assign rst_done = rst_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl. Two instances share one stimulus stream:
//   u_dut0 uses the defaults with STAGE_DLY=4.
//   u_dut1 uses the corner set NUM_OUT=1, STAGE_DLY=1, SYNC_STAGES=3.
// The reference model only tracks how many edges have passed since the last
// resetb rise or accepted sw_rst. It derives the expected outputs from the
// release-time formulas.
module tb_rst_seq_ctrl;

  typedef struct {
    int s;
    int n;
    int d;
    int h;
  } cfg_t;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       sw_rst = 1'b0;
  logic [2:0] rst_outb0;
  logic       rst_done0;
  logic       busy0;
  logic [0:0] rst_outb1;
  logic       rst_done1;
  logic       busy1;

  int n_vec = 0;
  int n_err = 0;

  cfg_t cfg[2];
  bit   warm[2];
  int   ecnt[2];

  always #5 clk = ~clk;

  rst_seq_ctrl #(.SYNC_STAGES(2), .NUM_OUT(3), .STAGE_DLY(4), .HOLD_CYC(8), .CNT_W(8)) u_dut0 (
    .clk      (clk),
    .resetb   (resetb),
    .sw_rst   (sw_rst),
    .rst_outb (rst_outb0),
    .rst_done (rst_done0),
    .busy     (busy0)
  );

  rst_seq_ctrl #(.SYNC_STAGES(3), .NUM_OUT(1), .STAGE_DLY(1), .HOLD_CYC(3), .CNT_W(4)) u_dut1 (
    .clk      (clk),
    .resetb   (resetb),
    .sw_rst   (sw_rst),
    .rst_outb (rst_outb1),
    .rst_done (rst_done1),
    .busy     (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Number of released bits e edges after the anchor (resetb rise or accepted sw_rst).
  function automatic int released(input cfg_t c, input bit w, input int e);
    int base;
    int k;
    base = w ? c.h : c.s;
    if (e < base) return 0;
    k = (e - base) / c.d;
    return (k > c.n) ? c.n : k;
  endfunction

  // sw_rst counts only when the block is already in RELEASE or DONE before the edge.
  function automatic bit honored(input cfg_t c, input bit w, input int e_new);
    return w ? (e_new >= c.h + 1) : (e_new >= c.s + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      warm[i] = 1'b0;
      ecnt[i] = 0;
    end
  endtask

  task automatic model_step();
    int e_new;
    if (resetb) begin
      for (int i = 0; i < 2; i++) begin
        e_new = ecnt[i] + 1;
        if (sw_rst && honored(cfg[i], warm[i], e_new)) begin
          warm[i] = 1'b1;
          ecnt[i] = 0;
        end else begin
          ecnt[i] = e_new;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int k0;
    int k1;
    k0 = resetb ? released(cfg[0], warm[0], ecnt[0]) : 0;
    k1 = resetb ? released(cfg[1], warm[1], ecnt[1]) : 0;
    check("d0_outb", 32'(rst_outb0), (32'd1 << k0) - 32'd1);
    check("d0_done", 32'(rst_done0), 32'(k0 == cfg[0].n));
    check("d0_busy", 32'(busy0),     32'(k0 != cfg[0].n));
    check("d1_outb", 32'(rst_outb1), (32'd1 << k1) - 32'd1);
    check("d1_done", 32'(rst_done1), 32'(k1 == cfg[1].n));
    check("d1_busy", 32'(busy1),     32'(k1 != cfg[1].n));
  endtask

  // One clock cycle. Outputs are checked at the falling edge and then the inputs
  // are driven. rb: 0 = resetb high, 1 = 3 ns low pulse, 2 = pull low and keep low.
  task automatic cycle(input bit sw, input int rb);
    @(negedge clk);
    check_outputs();
    sw_rst = sw;
    case (rb)
      1: begin
        #1 resetb = 1'b0;
        model_reset();
        #1 check_outputs();
        #2 resetb = 1'b1;
      end
      2: begin
        #1 resetb = 1'b0;
        model_reset();
        #1 check_outputs();
      end
      default: begin
        if (!resetb) #2 resetb = 1'b1;
      end
    endcase
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  initial begin
    int r;
    cfg[0] = '{s: 2, n: 3, d: 4, h: 8};
    cfg[1] = '{s: 3, n: 1, d: 1, h: 3};
    model_reset();

    // Power-on: hold resetb low, then release and let the sequence finish.
    cycle(1'b0, 2);
    cycle(1'b0, 2);
    cycle(1'b0, 2);
    idle(18);
    // Warm reset from DONE.
    cycle(1'b1, 0);
    idle(24);
    // Short asynchronous pulse while in DONE.
    cycle(1'b0, 1);
    idle(18);
    // sw_rst just after bit 0 is released, then again while in HOLD.
    cycle(1'b0, 1);
    idle(6);
    cycle(1'b1, 0);
    idle(3);
    cycle(1'b1, 0);
    idle(22);
    // resetb pulses in the middle of HOLD and in the middle of RELEASE.
    cycle(1'b1, 0);
    idle(4);
    cycle(1'b0, 1);
    idle(8);
    cycle(1'b0, 1);
    idle(20);

    // Randomized mix of sw_rst requests, short pulses and longer resets.
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 3)       cycle(1'b0, 2);
      else if (r < 8)  cycle(1'b0, 1);
      else if (r < 24) cycle(1'b1, 0);
      else             cycle(1'b0, 0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
